bt_uart_tx: RTL and testbench

Buffered UART transmitter for the Bluetooth serial module link: the transmit-side counterpart of the existing receiver path. It accepts bytes from the host logic through a small FIFO and serializes them on `tx` as 8N1 frames (optionally 8E1) at a baud rate derived from the system clock. It sits beside the receiver inside the Bluetooth peripheral and drives the module's RX pin.

---
 rtl/bt_uart_tx_if.sv | 28 ++
 rtl/bt_uart_tx.sv | 177 +++++++++++++++++
 tb/tb_bt_uart_tx.sv | 399 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bt_uart_tx_if.sv
// Host-side write port and line-side status of the Bluetooth UART transmitter.
// master: host logic driving bytes in; slave: the transmitter itself.
interface bt_uart_tx_if;
   logic [7:0] din;
   logic       enable;
   logic       full;
   logic       busy;
   logic       done;
   logic       tx;

   modport master (
      output din,
      output enable,
      input  full,
      input  busy,
      input  done,
      input  tx
   );

   modport slave (
      input  din,
      input  enable,
      output full,
      output busy,
      output done,
      output tx
   );
endinterface

// File: rtl/bt_uart_tx.sv
// Buffered 8N1 UART transmitter for the Bluetooth module link (FIFO + serializer FSM).
// Define BT_TX_PARITY_EN to compile in an even-parity bit (8E1 frames).
module bt_uart_tx #(
   parameter int CLK_HZ = 50000000,
   parameter int BAUD   = 9600,
   parameter int DEPTH  = 4
) (
   input  logic        clk_in,
   input  logic        reset,
   bt_uart_tx_if.slave bus
);

   localparam int DIVISOR = CLK_HZ / BAUD;
   localparam int CNT_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam int AW      = $clog2(DEPTH);
   localparam int PTR_W   = AW + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);

`ifdef BT_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   logic [7:0]       mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             fifo_empty, fifo_full;
   logic             push, pop;
   logic [7:0]       head;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic             tx_q, tx_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic [7:0]       shift_q;
   logic             cnt_last;
`ifdef BT_TX_PARITY_EN
   logic             parity_q;
`endif

   // FIFO: extra pointer MSB distinguishes full from empty when the index bits match
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push       = bus.enable & ~fifo_full;
   assign head       = mem_q[rd_ptr_q[AW-1:0]];
   assign wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
   assign rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

   always_ff @(posedge clk_in) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= bus.din;
      end
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Serializer data path: loaded once per frame when IDLE pops the head byte
   always_ff @(posedge clk_in) begin
      if (pop) begin
         shift_q  <= head;
`ifdef BT_TX_PARITY_EN
         parity_q <= ^head;
`endif
      end
   end

   assign cnt_last = (cnt_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      tx_d    = 1'b1;
      done_d  = 1'b0;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               cnt_d   = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            tx_d = 1'b0;
            if (cnt_last) begin
               cnt_d   = '0;
               bit_d   = 3'd0;
               state_d = S_DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DATA: begin
            tx_d = shift_q[bit_q];
            if (cnt_last) begin
               cnt_d = '0;
               if (bit_q == 3'd7) begin
`ifdef BT_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`ifdef BT_TX_PARITY_EN
         S_PARITY: begin
            tx_d = parity_q;
            if (cnt_last) begin
               cnt_d   = '0;
               state_d = S_STOP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`endif
         S_STOP: begin
            if (cnt_last) begin
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // tx, done and busy are registered from the current state, so busy trails the
   // state by one clock and stays high until the last stop-bit clock on tx is over
   assign busy_d = (state_q != S_IDLE) | ~fifo_empty;

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.tx   = tx_q;
   assign bus.done = done_q;
   assign bus.busy = busy_q;
   assign bus.full = fifo_full;

endmodule

// File: tb/tb_bt_uart_tx.sv
// Directed bench for bt_uart_tx at DIVISOR=10, DEPTH=4; honours BT_TX_PARITY_EN.
module tb_bt_uart_tx;
   localparam int DIV = 10;
`ifdef BT_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * DIV;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   errors   = 0;
   int   checks   = 0;
   int   cyc      = 0;
   int   done_cnt = 0;

   bt_uart_tx_if ifc();

   bt_uart_tx #(.CLK_HZ(1000000), .BAUD(100000), .DEPTH(4)) dut (
      .clk_in (clk),
      .reset  (rst_n),
      .bus    (ifc.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (ifc.done === 1'b1) done_cnt <= done_cnt + 1;

   task automatic write_byte(input logic [7:0] b);
      @(negedge clk);
      ifc.enable = 1'b1;
      ifc.din    = b;
      @(negedge clk);
      ifc.enable = 1'b0;
   endtask

   // Returns on the frame's last stop-bit clock (index FRAME-1 from the start bit).
   task automatic recv_frame(input logic [7:0] exp, output int start);
      int guard;
      logic [7:0] got;
      guard = 0;
      start = 0;
      got   = 8'h00;
      while (ifc.tx !== 1'b0 && guard < 4000) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (guard >= 4000) begin
         errors++;
         $display("FAIL frame_timeout: tx=%b, required a start bit for byte %h", ifc.tx, exp);
         return;
      end
      start = cyc;
      repeat (DIV/2) @(negedge clk);
      checks++;
      if (ifc.tx !== 1'b0) begin
         errors++;
         $display("FAIL start_bit: tx=%b, required 0 (byte %h)", ifc.tx, exp);
      end
      for (int i = 0; i < 8; i++) begin
         repeat (DIV) @(negedge clk);
         got[i] = ifc.tx;
      end
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL frame_data: got %h, required %h", got, exp);
      end
`ifdef BT_TX_PARITY_EN
      repeat (DIV) @(negedge clk);
      checks++;
      if (ifc.tx !== ^exp) begin
         errors++;
         $display("FAIL parity_bit: tx=%b, required %b (byte %h)", ifc.tx, ^exp, exp);
      end
`endif
      repeat (DIV) @(negedge clk);
      checks++;
      if (ifc.tx !== 1'b1) begin
         errors++;
         $display("FAIL stop_bit: tx=%b, required 1 (byte %h)", ifc.tx, exp);
      end
      repeat (DIV/2 - 2) @(negedge clk);
      checks++;
      if (ifc.done !== 1'b0) begin
         errors++;
         $display("FAIL done_early: done=%b one clock before end, required 0", ifc.done);
      end
      @(negedge clk);
      checks++;
      if (ifc.done !== 1'b1 || ifc.tx !== 1'b1) begin
         errors++;
         $display("FAIL done_pulse: done=%b tx=%b at last stop clock, required 1/1", ifc.done, ifc.tx);
      end
   endtask

   task automatic test_reset();
      ifc.enable = 1'b0;
      ifc.din    = 8'h00;
      rst_n      = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({ifc.tx, ifc.busy, ifc.done, ifc.full} !== 4'b1000) begin
         errors++;
         $display("FAIL reset_outputs: tx/busy/done/full=%b, required 1000",
                  {ifc.tx, ifc.busy, ifc.done, ifc.full});
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({ifc.tx, ifc.busy, ifc.done, ifc.full} !== 4'b1000) begin
         errors++;
         $display("FAIL post_reset: tx/busy/done/full=%b, required 1000",
                  {ifc.tx, ifc.busy, ifc.done, ifc.full});
      end
   endtask

   task automatic test_idle();
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         checks++;
         if ({ifc.tx, ifc.busy, ifc.done, ifc.full} !== 4'b1000) begin
            errors++;
            $display("FAIL idle_line: cycle %0d tx/busy/done/full=%b, required 1000", i,
                     {ifc.tx, ifc.busy, ifc.done, ifc.full});
            break;
         end
      end
   endtask

   task automatic test_single();
      int d0, st;
      d0 = done_cnt;
      write_byte(8'h55);
      checks++;
      if (ifc.tx !== 1'b1) begin
         errors++;
         $display("FAIL tx_latency1: tx=%b one clock after write, required 1", ifc.tx);
      end
      @(negedge clk);
      checks++;
      if (ifc.tx !== 1'b1 || ifc.busy !== 1'b1) begin
         errors++;
         $display("FAIL tx_latency2: tx=%b busy=%b two clocks after write, required 1/1", ifc.tx, ifc.busy);
      end
      @(negedge clk);
      checks++;
      if (ifc.tx !== 1'b0) begin
         errors++;
         $display("FAIL tx_fall: tx=%b after write+2, required 0", ifc.tx);
      end
      recv_frame(8'h55, st);
      checks++;
      if (ifc.busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_at_done: busy=%b, required 1", ifc.busy);
      end
      @(negedge clk);
      checks++;
      if (ifc.busy !== 1'b0 || ifc.tx !== 1'b1 || ifc.done !== 1'b0) begin
         errors++;
         $display("FAIL after_frame: busy=%b tx=%b done=%b, required 0/1/0", ifc.busy, ifc.tx, ifc.done);
      end
      checks++;
      if (done_cnt - d0 !== 1) begin
         errors++;
         $display("FAIL single_done_count: %0d pulses, required 1", done_cnt - d0);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] b[5];
      int st[5];
      int d0;
      b  = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hFF};
      d0 = done_cnt;
      fork
         begin
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               if (i == 4) begin
                  checks++;
                  if (ifc.full !== 1'b0) begin
                     errors++;
                     $display("FAIL full_after_4th: full=%b, required 0 (head already popped)", ifc.full);
                  end
               end
               ifc.enable = 1'b1;
               ifc.din    = b[i];
            end
            @(negedge clk);
            ifc.enable = 1'b0;
            checks++;
            if (ifc.full !== 1'b1) begin
               errors++;
               $display("FAIL full_after_5th: full=%b, required 1", ifc.full);
            end
         end
         begin
            for (int k = 0; k < 5; k++) recv_frame(b[k], st[k]);
         end
      join
      for (int k = 1; k < 5; k++) begin
         checks++;
         if (st[k] - st[k-1] !== FRAME + 1) begin
            errors++;
            $display("FAIL b2b_gap: frame %0d start spacing %0d, required %0d", k, st[k] - st[k-1], FRAME + 1);
         end
      end
      @(negedge clk);
      checks++;
      if (done_cnt - d0 !== 5) begin
         errors++;
         $display("FAIL b2b_done_count: %0d pulses, required 5", done_cnt - d0);
      end
   endtask

   task automatic test_full_drop();
      logic [7:0] b[5];
      int st[5];
      int d0, bad;
      b  = '{8'h11, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
      d0 = done_cnt;
      fork
         begin
            write_byte(8'h11);
            repeat (4) @(negedge clk);
            for (int i = 1; i < 5; i++) begin
               ifc.enable = 1'b1;
               ifc.din    = b[i];
               @(negedge clk);
            end
            checks++;
            if (ifc.full !== 1'b1) begin
               errors++;
               $display("FAIL full_set: full=%b after 4 writes mid-frame, required 1", ifc.full);
            end
            ifc.din = 8'hEE;
            @(negedge clk);
            ifc.enable = 1'b0;
            checks++;
            if (ifc.full !== 1'b1) begin
               errors++;
               $display("FAIL full_hold: full=%b after dropped write, required 1", ifc.full);
            end
         end
         begin
            for (int k = 0; k < 5; k++) recv_frame(b[k], st[k]);
         end
      join
      @(negedge clk);
      checks++;
      if (done_cnt - d0 !== 5) begin
         errors++;
         $display("FAIL drop_done_count: %0d pulses, required 5", done_cnt - d0);
      end
      bad = 0;
      repeat (FRAME + 20) begin
         @(negedge clk);
         if (ifc.tx !== 1'b1 || ifc.busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL dropped_byte_sent: %0d non-idle clocks, required 0", bad);
      end
   endtask

   task automatic test_reset_midframe();
      int d0, bad, st;
      write_byte(8'h3C);
      repeat (2) @(negedge clk);
      checks++;
      if (ifc.tx !== 1'b0) begin
         errors++;
         $display("FAIL rst_frame_start: tx=%b, required 0", ifc.tx);
      end
      repeat (45) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({ifc.tx, ifc.busy, ifc.done, ifc.full} !== 4'b1000) begin
         errors++;
         $display("FAIL async_reset: tx/busy/done/full=%b, required 1000",
                  {ifc.tx, ifc.busy, ifc.done, ifc.full});
      end
      d0 = done_cnt;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      repeat (150) begin
         @(negedge clk);
         if (ifc.tx !== 1'b1 || ifc.busy !== 1'b0 || ifc.done !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL flush_after_reset: %0d non-idle clocks, required 0", bad);
      end
      checks++;
      if (done_cnt != d0) begin
         errors++;
         $display("FAIL truncated_done: %0d pulses, required 0", done_cnt - d0);
      end
      d0 = done_cnt;
      fork
         write_byte(8'h81);
         recv_frame(8'h81, st);
      join
      @(negedge clk);
      checks++;
      if (done_cnt - d0 !== 1) begin
         errors++;
         $display("FAIL clean_frame_done: %0d pulses, required 1", done_cnt - d0);
      end
   endtask

`ifdef BT_TX_PARITY_EN
   task automatic test_parity();
      int st;
      fork
         write_byte(8'h07);
         recv_frame(8'h07, st);
      join
      @(negedge clk);
      fork
         write_byte(8'h03);
         recv_frame(8'h03, st);
      join
      @(negedge clk);
   endtask
`endif

   task automatic test_burst9();
      logic [7:0] b[9];
      int st[9];
      int d0;
      b  = '{8'h01, 8'h80, 8'h5A, 8'hC3, 8'h7E, 8'h00, 8'hFF, 8'h96, 8'h2D};
      d0 = done_cnt;
      fork
         begin
            int i, guard;
            i = 0;
            guard = 0;
            while (i < 9 && guard < 5000) begin
               @(negedge clk);
               guard++;
               if (ifc.full === 1'b0) begin
                  ifc.enable = 1'b1;
                  ifc.din    = b[i];
                  i++;
               end else begin
                  ifc.enable = 1'b0;
               end
            end
            @(negedge clk);
            ifc.enable = 1'b0;
            checks++;
            if (i != 9) begin
               errors++;
               $display("FAIL burst_writes: %0d written, required 9", i);
            end
         end
         begin
            for (int k = 0; k < 9; k++) recv_frame(b[k], st[k]);
         end
      join
      for (int k = 1; k < 9; k++) begin
         checks++;
         if (st[k] - st[k-1] !== FRAME + 1) begin
            errors++;
            $display("FAIL burst_gap: frame %0d spacing %0d, required %0d", k, st[k] - st[k-1], FRAME + 1);
         end
      end
      @(negedge clk);
      checks++;
      if (done_cnt - d0 !== 9) begin
         errors++;
         $display("FAIL burst_done_count: %0d pulses, required 9", done_cnt - d0);
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_single();
      test_back_to_back();
      test_full_drop();
      test_reset_midframe();
`ifdef BT_TX_PARITY_EN
      test_parity();
`endif
      test_burst9();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
